// File: rtl/rst_seq_pkg.sv
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared state encodings and helpers for the reset sequencer
//               and its debug register block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    localparam int unsigned RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_MRST  = 3'd0,
        ST_WLOCK = 3'd1,
        ST_HOLD  = 3'd2,
        ST_REL   = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// Module      : rst_seq_ctrl
// Description : MMCM reset / lock-wait / staged domain reset release sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOM        = 4,
    parameter int MMCM_RST_CYC = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int HOLD_CNT     = 50,
    parameter int STAGE_CNT    = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               mmcm_locked_i,
    input  logic               sw_rst_req_i,
    output logic               mmcm_rst_o,
    output logic [N_DOM-1:0]   dom_rst_n_o,
    output logic               seq_done_o,
    output logic               sw_rst_ack_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [2:0]         state_o
);

    localparam int REL_END = N_DOM * STAGE_CNT;
    localparam int CNT_MAX = max2(max2(LOCK_TIMEOUT, HOLD_CNT),
                                  max2(REL_END + 1, MMCM_RST_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MRST    = CNT_W'(MMCM_RST_CYC);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] C_HOLD    = CNT_W'(HOLD_CNT);
    localparam logic [CNT_W-1:0] C_RUN_AT  = CNT_W'(REL_END + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_DOM-1:0]     dom_q, dom_d;
    logic                 ack_q, ack_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 locked;
    logic                 abort;
    logic [N_DOM-1:0]     rel_hit;

    sync_2ff u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (mmcm_locked_i),
        .q_o     (locked)
    );

    // cnt_q is the 1-based cycle index within the current state
    for (genvar i = 0; i < N_DOM; i++) begin : g_rel
        assign rel_hit[i] = (cnt_q >= CNT_W'((i + 1) * STAGE_CNT));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        dom_d   = '0;
        ack_d   = 1'b0;
        retry_d = retry_q;
        abort   = 1'b0;
        case (state_q)
            ST_MRST: begin
                if (cnt_q >= C_MRST) begin
                    state_d = ST_WLOCK;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WLOCK: begin
                if (sw_rst_req_i) begin
                    abort = 1'b1;
                end else if (locked) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= C_TIMEOUT) begin
                    state_d = ST_MRST;
                    cnt_d   = CNT_ONE;
                    retry_d = sat_inc(retry_q);
                end
            end
            ST_HOLD: begin
                if (sw_rst_req_i || !locked) begin
                    abort = 1'b1;
                end else if (cnt_q >= C_HOLD) begin
                    state_d = ST_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_REL: begin
                if (sw_rst_req_i || !locked) begin
                    abort = 1'b1;
                end else begin
                    dom_d = dom_q | rel_hit;
                    if (cnt_q >= C_RUN_AT) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
            end
            ST_RUN: begin
                if (sw_rst_req_i || !locked) begin
                    abort = 1'b1;
                end else begin
                    dom_d = dom_q;
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_MRST;
                cnt_d   = CNT_ONE;
            end
        endcase
        // Lock loss and software request share one MRST entry; ack follows the request
        if (abort) begin
            state_d = ST_MRST;
            cnt_d   = CNT_ONE;
            dom_d   = '0;
            ack_d   = sw_rst_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_MRST;
            cnt_q   <= '0;
            dom_q   <= '0;
            ack_q   <= 1'b0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            ack_q   <= ack_d;
            retry_q <= retry_d;
        end
    end

    assign mmcm_rst_o   = (state_q == ST_MRST);
    assign seq_done_o   = (state_q == ST_RUN);
    assign dom_rst_n_o  = dom_q;
    assign sw_rst_ack_o = ack_q;
    assign retry_cnt_o  = retry_q;
    assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Self-checking bench for rst_seq_ctrl with a phase/age model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

    localparam int N_DOM        = 3;
    localparam int MMCM_RST_CYC = 4;
    localparam int LOCK_TIMEOUT = 100;
    localparam int HOLD_CNT     = 10;
    localparam int STAGE_CNT    = 5;

    localparam int P_MRST = 0, P_WLOCK = 1, P_HOLD = 2, P_REL = 3, P_RUN = 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             locked = 1'b0;
    logic             sw_req = 1'b0;
    logic             mmcm_rst, seq_done, sw_ack;
    logic [N_DOM-1:0] dom_rst_n;
    logic [3:0]       retry;
    logic [2:0]       state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: phase plus age (edges since phase entry), lock seen through 2 stages
    typedef struct {
        int cyc;
        int phase;
        int age;
        int retry;
        bit ack;
        bit s1;
        bit s2;
    } m_t;

    m_t m;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .N_DOM        (N_DOM),
        .MMCM_RST_CYC (MMCM_RST_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .HOLD_CNT     (HOLD_CNT),
        .STAGE_CNT    (STAGE_CNT)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .mmcm_locked_i (locked),
        .sw_rst_req_i  (sw_req),
        .mmcm_rst_o    (mmcm_rst),
        .dom_rst_n_o   (dom_rst_n),
        .seq_done_o    (seq_done),
        .sw_rst_ack_o  (sw_ack),
        .retry_cnt_o   (retry),
        .state_o       (state)
    );

    function automatic m_t m_reset();
        m_t r;
        r.cyc = 0; r.phase = P_MRST; r.age = -1; r.retry = 0;
        r.ack = 1'b0; r.s1 = 1'b0; r.s2 = 1'b0;
        return r;
    endfunction

    function automatic m_t m_step(input m_t c, input logic sw, input logic lk_in);
        m_t n;
        bit lk;
        bit ab;
        n = c;
        lk = c.s2;
        n.cyc = c.cyc + 1;
        n.s2 = c.s1;
        n.s1 = lk_in;
        n.ack = 1'b0;
        n.age = c.age + 1;
        ab = (c.phase != P_MRST) && (sw || (!lk && c.phase != P_WLOCK));
        if (ab) begin
            n.phase = P_MRST; n.age = 0; n.ack = sw;
        end else begin
            case (c.phase)
                P_MRST:  if (n.age == MMCM_RST_CYC) begin n.phase = P_WLOCK; n.age = 0; end
                P_WLOCK: if (lk) begin
                             n.phase = P_HOLD; n.age = 0;
                         end else if (n.age == LOCK_TIMEOUT) begin
                             n.phase = P_MRST; n.age = 0;
                             n.retry = (c.retry < 15) ? c.retry + 1 : 15;
                         end
                P_HOLD:  if (n.age == HOLD_CNT) begin n.phase = P_REL; n.age = 0; end
                P_REL:   if (n.age == N_DOM * STAGE_CNT + 1) begin n.phase = P_RUN; n.retry = 0; end
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic [N_DOM-1:0] exp_dom(input m_t s);
        logic [N_DOM-1:0] r;
        r = '0;
        for (int i = 0; i < N_DOM; i++)
            if (s.phase == P_RUN || (s.phase == P_REL && s.age >= (i + 1) * STAGE_CNT))
                r[i] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= m_step(m, sw_req, locked);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_mmcm_rst", 32'(mmcm_rst),  32'(m.phase == P_MRST));
            chk("mdl_dom_rst_n", 32'(dom_rst_n), 32'(exp_dom(m)));
            chk("mdl_seq_done", 32'(seq_done),  32'(m.phase == P_RUN));
            chk("mdl_sw_ack",   32'(sw_ack),    32'(m.ack));
            chk("mdl_retry",    32'(retry),     32'(m.retry));
            chk("mdl_state",    32'(state),     32'(m.phase));
        end
    end

    task automatic at_cycle(input int n);
        while (m.cyc < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", m.cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mmcm",  32'(mmcm_rst), 32'd1);
        chk("rst_dom",   32'(dom_rst_n), 32'd0);
        chk("rst_retry", 32'(retry), 32'd0);
        rst_n = 1'b1;

        // Normal bring-up
        at_cycle(1);  chk("mrst_c1", 32'(mmcm_rst), 32'd1);
        at_cycle(4);  chk("mrst_c4", 32'(mmcm_rst), 32'd1);
        at_cycle(5);  chk("mrst_end", 32'(mmcm_rst), 32'd0); chk("wlock_c5", 32'(state), 32'd1);
        at_cycle(19); locked = 1'b1;
        at_cycle(21); chk("wlock_c21", 32'(state), 32'd1);
        at_cycle(22); chk("hold_c22", 32'(state), 32'd2);
        at_cycle(32); chk("rel_c32", 32'(state), 32'd3);
        at_cycle(36); chk("dom_c36", 32'(dom_rst_n), 32'd0);
        at_cycle(37); chk("dom_c37", 32'(dom_rst_n), 32'd1);
        at_cycle(42); chk("dom_c42", 32'(dom_rst_n), 32'd3);
        at_cycle(47); chk("dom_c47", 32'(dom_rst_n), 32'd7); chk("done_c47", 32'(seq_done), 32'd0);
        at_cycle(48); chk("run_c48", 32'(state), 32'd4); chk("done_c48", 32'(seq_done), 32'd1);

        // Software reset in RUN, then ignored request in MRST
        at_cycle(60); sw_req = 1'b1;
        at_cycle(61); sw_req = 1'b0;
        chk("sw_ack_c61", 32'(sw_ack), 32'd1); chk("sw_dom_c61", 32'(dom_rst_n), 32'd0);
        at_cycle(62); sw_req = 1'b1; chk("sw_ack_c62", 32'(sw_ack), 32'd0);
        at_cycle(63); sw_req = 1'b0; chk("mrst_noack_c63", 32'(sw_ack), 32'd0);
        at_cycle(64); chk("mrst_noack_c64", 32'(sw_ack), 32'd0);
        at_cycle(65); chk("wlock_c65", 32'(state), 32'd1);

        // Lock loss in RUN
        at_cycle(99);  locked = 1'b0;
        at_cycle(101); chk("loss_dom_c101", 32'(dom_rst_n), 32'd7);
        at_cycle(102); chk("loss_dom_c102", 32'(dom_rst_n), 32'd0); chk("loss_st_c102", 32'(state), 32'd0);
        at_cycle(109); locked = 1'b1;
        at_cycle(138); chk("reseq_run_c138", 32'(state), 32'd4);

        // Glitch in HOLD
        at_cycle(149); locked = 1'b0;
        at_cycle(159); locked = 1'b1;
        at_cycle(166); locked = 1'b0;
        at_cycle(167); locked = 1'b1;
        at_cycle(168); chk("glitch_hold_c168", 32'(state), 32'd2);
        at_cycle(169); chk("glitch_mrst_c169", 32'(state), 32'd0);
        at_cycle(183); chk("glitch_dom_c183", 32'(dom_rst_n), 32'd0);
        at_cycle(200); chk("glitch_run_c200", 32'(state), 32'd4);

        // Lock timeout retries and saturation
        at_cycle(209);  locked = 1'b0;
        at_cycle(315);  chk("to_st_c315", 32'(state), 32'd1); chk("to_retry_c315", 32'(retry), 32'd0);
        at_cycle(316);  chk("to_st_c316", 32'(state), 32'd0); chk("to_retry_c316", 32'(retry), 32'd1);
        at_cycle(420);  chk("to_retry_c420", 32'(retry), 32'd2);
        at_cycle(1772); chk("to_retry_c1772", 32'(retry), 32'd15);
        at_cycle(1876); chk("to_sat_c1876", 32'(retry), 32'd15); chk("to_st_c1876", 32'(state), 32'd0);
        at_cycle(1999); locked = 1'b1;
        at_cycle(2027); chk("clr_retry_c2027", 32'(retry), 32'd15);
        at_cycle(2028); chk("clr_retry_c2028", 32'(retry), 32'd0); chk("clr_run_c2028", 32'(state), 32'd4);

        // Coincident lock loss and software request
        at_cycle(2047); locked = 1'b0;
        at_cycle(2049); sw_req = 1'b1;
        at_cycle(2050); sw_req = 1'b0;
        chk("coinc_ack_c2050", 32'(sw_ack), 32'd1); chk("coinc_st_c2050", 32'(state), 32'd0);
        at_cycle(2051); chk("coinc_ack_c2051", 32'(sw_ack), 32'd0);
        at_cycle(2053); chk("coinc_st_c2053", 32'(state), 32'd0);
        at_cycle(2054); chk("coinc_st_c2054", 32'(state), 32'd1);

        // Asynchronous reset mid-REL
        at_cycle(2059); locked = 1'b1;
        at_cycle(2072); chk("arst_rel_c2072", 32'(state), 32'd3);
        at_cycle(2079); chk("arst_dom_c2079", 32'(dom_rst_n), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_mmcm", 32'(mmcm_rst), 32'd1);
        chk("arst_dom", 32'(dom_rst_n), 32'd0);
        chk("arst_done", 32'(seq_done), 32'd0);
        chk("arst_ack", 32'(sw_ack), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        at_cycle(4); chk("rerst_st_c4", 32'(state), 32'd0);
        at_cycle(5); chk("rerst_st_c5", 32'(state), 32'd1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter N_DOM, default 4: number of sequenced reset domains.
REQ-002 SHALL have parameter MMCM_RST_CYC, default 8: clk_i cycles mmcm_rst_o is held high per attempt.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: clk_i cycles to wait for lock before retrying.
REQ-004 SHALL have parameter HOLD_CNT, default 50: clk_i cycles of stable lock before the first domain release.
REQ-005 SHALL have parameter STAGE_CNT, default 16: clk_i cycles between successive domain releases.
REQ-006 SHALL have port clk_i, input, 1: single free-running reference clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_i, input, 1: asynchronous active-low reset, already synchronised for deassertion.
REQ-008 SHALL have port mmcm_locked_i, input, 1: MMCM locked flag, asynchronous to clk_i.
REQ-009 SHALL have port sw_rst_req_i, input, 1: single-cycle software request for a full re-sequence.
REQ-010 SHALL have port mmcm_rst_o, output, 1: active-high MMCM reset.
REQ-011 SHALL have port dom_rst_n_o, output, N_DOM: active-low domain resets; bit 0 is released first.
REQ-012 SHALL have port seq_done_o, output, 1: high only in RUN.
REQ-013 SHALL have port sw_rst_ack_o, output, 1: one-cycle acknowledge of an accepted sw_rst_req_i.
REQ-014 SHALL have port retry_cnt_o, output, 4: lock-timeout retry count, saturating at 15.
REQ-015 SHALL have port state_o, output, 3: current state encoding for debug.

Function
REQ-016 SHALL pass mmcm_locked_i through a 2-flop synchroniser; "locked" below means the synchronised value.
REQ-017 SHALL implement states MRST=0, WLOCK=1, HOLD=2, REL=3, RUN=4; other encodings SHALL go to MRST.
REQ-018 In MRST, SHALL drive mmcm_rst_o=1 for exactly MMCM_RST_CYC cycles, then enter WLOCK.
REQ-019 In WLOCK, SHALL enter HOLD on the first cycle locked=1, and SHALL enter MRST with retry_cnt_o+1 (saturating) after LOCK_TIMEOUT cycles without lock.
REQ-020 In HOLD, SHALL enter REL after HOLD_CNT consecutive cycles with locked=1, and SHALL enter MRST if locked drops.
REQ-021 In REL, SHALL release dom_rst_n_o[i] at (i+1)*STAGE_CNT cycles after entry (i=0..N_DOM-1), and SHALL enter RUN on the cycle after the last release.
REQ-022 Releases SHALL be monotonic: a released bit SHALL stay high until the next MRST entry.
REQ-023 On a locked 1->0 transition in REL or RUN, SHALL drive all dom_rst_n_o low on the next edge and enter MRST.
REQ-024 SHALL accept sw_rst_req_i in WLOCK, HOLD, REL and RUN, pulse sw_rst_ack_o on the next cycle, drive all dom_rst_n_o low and enter MRST.
REQ-025 SHALL ignore sw_rst_req_i in MRST, with no acknowledge.
REQ-026 When lock loss and sw_rst_req_i coincide, SHALL enter MRST once and still assert sw_rst_ack_o.
REQ-027 SHALL clear retry_cnt_o on RUN entry.
REQ-028 SHALL hold all dom_rst_n_o low in MRST, WLOCK and HOLD, and SHALL drive seq_done_o=1 only in RUN.
REQ-029 SHALL size every counter to the maximum of LOCK_TIMEOUT, HOLD_CNT, N_DOM*STAGE_CNT and MMCM_RST_CYC, with no wrap-around in use.

Reset
REQ-030 While rst_n_i=0, SHALL asynchronously set state=MRST, mmcm_rst_o=1, dom_rst_n_o=0, seq_done_o=0, sw_rst_ack_o=0, retry_cnt_o=0, counters=0 and synchroniser flops=0.
REQ-031 After rst_n_i rises, SHALL start the MRST count on the first clk_i edge.
REQ-032 An assertion of rst_n_i at any point SHALL abort the sequence immediately.

Structure
REQ-033 The state encodings SHALL be defined as constants in package rst_seq_pkg, shared with the debug register block.
REQ-034 The mmcm_locked_i synchroniser SHALL be a separate sub-module, sync_2ff.

Verification
Test parameters: N_DOM=3, MMCM_RST_CYC=4, LOCK_TIMEOUT=100, HOLD_CNT=10, STAGE_CNT=5.
REQ-035 Normal bring-up: release rst_n_i, raise locked at cycle 20 -> mmcm_rst_o high for cycles 1-4, dom bits release at HOLD exit +5/+10/+15, seq_done_o=1 after that.
REQ-036 Lock timeout: locked held 0 -> return to MRST every 104 cycles, retry_cnt_o steps 1,2,...,15 and holds at 15, then clears on RUN.
REQ-037 Lock loss in RUN: drop locked -> all dom_rst_n_o=0 three edges later (2 sync + 1), state MRST, full re-sequence follows.
REQ-038 Software reset: pulse sw_rst_req_i in RUN -> sw_rst_ack_o pulses once next cycle, dom_rst_n_o=0, and the same request pulsed in MRST gives no acknowledge.
REQ-039 Glitch in HOLD: drop locked for one synchronised cycle at HOLD count 7 -> MRST, no dom bit ever released.
REQ-040 Async reset mid-REL (after dom bit 0 released) -> all outputs at reset values without waiting for a clock edge.
